// File: rtl/stopwatch_display_scan.sv
// Multiplexes four snapshotted BCD stopwatch digits onto a common-anode 4-digit
// seven-segment display with colon blink, set-mode blink, leading-zero blanking.
module stopwatch_display_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 4,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_M1,
  input  logic [3:0] digit_M0,
  input  logic [3:0] digit_S1,
  input  logic [3:0] digit_S0,
  input  logic       start,
  input  logic       set_mode,
  input  logic [1:0] set_sel,
  input  logic       blank_lz,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       digit_err
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DEAD_MAX  = DW'(DEAD_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  typedef enum logic {GAP, DRIVE} state_t;

  function automatic logic digit_ok(input logic [3:0] d, input logic is_s1);
    return is_s1 ? (d <= 4'd5) : (d <= 4'd9);
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d, input logic ok);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return ok ? s : 7'b0111111;
  endfunction

  logic [PW-1:0] prescaler;
  logic [DW-1:0] dead_cnt, dead_nxt;
  logic [FW-1:0] frame_cnt;
  logic [1:0]    idx;
  logic          blink_phase, scan_live;
  logic [3:0]    snap_m1, snap_m0, snap_s1, snap_s0;
  state_t        state, state_nxt;
  logic          tick, blank, snap_bad;
  logic [3:0]    cur_digit;
  logic [3:0]    an_p0;
  logic [6:0]    seg_p0;
  logic          dp_p0;

  assign tick     = (prescaler == PRE_MAX);
  assign snap_bad = !digit_ok(digit_M1, 1'b0) || !digit_ok(digit_M0, 1'b0) ||
                    !digit_ok(digit_S1, 1'b1) || !digit_ok(digit_S0, 1'b0);

  // The dark gap only ends once a first tick has selected a real slot.
  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    if (tick) begin
      state_nxt = GAP;
      dead_nxt  = '0;
    end else if (state == GAP) begin
      if (dead_cnt == DEAD_MAX) begin
        if (scan_live) state_nxt = DRIVE;
      end else begin
        dead_nxt = dead_cnt + DW'(1);
      end
    end
  end

  // p0: next display value from current slot, snapshot and live mode inputs
  always_comb begin
    case (idx)
      2'd0:    cur_digit = snap_s0;
      2'd1:    cur_digit = snap_s1;
      2'd2:    cur_digit = snap_m0;
      default: cur_digit = snap_m1;
    endcase
    blank  = (blank_lz && idx == 2'd3 && snap_m1 == 4'd0) ||
             (set_mode && set_sel == idx && blink_phase);
    an_p0  = 4'hF;
    seg_p0 = 7'h7F;
    dp_p0  = 1'b1;
    if (state_nxt == DRIVE && !blank) begin
      an_p0  = ~(4'b0001 << idx);
      seg_p0 = seg_encode(cur_digit, digit_ok(cur_digit, idx == 2'd1));
      dp_p0  = !(idx == 2'd2 && (!start || !blink_phase));
    end
  end

  // p1: registered control, snapshot and pin outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      prescaler   <= '0;
      idx         <= 2'd3;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      scan_live   <= 1'b0;
      dead_cnt    <= '0;
      state       <= GAP;
      snap_m1     <= '0;
      snap_m0     <= '0;
      snap_s1     <= '0;
      snap_s0     <= '0;
      digit_err   <= 1'b0;
      an_n        <= 4'hF;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      state     <= state_nxt;
      dead_cnt  <= dead_nxt;
      an_n      <= an_p0;
      seg_n     <= seg_p0;
      dp_n      <= dp_p0;
      if (tick) begin
        idx       <= idx + 2'd1;
        scan_live <= 1'b1;
        if (idx == 2'd3) begin
          snap_m1 <= digit_M1;
          snap_m0 <= digit_M0;
          snap_s1 <= digit_S1;
          snap_s0 <= digit_S0;
          if (snap_bad) digit_err <= 1'b1;
          if (frame_cnt == FRAME_MAX) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed bench for stopwatch_display_scan with REFRESH_DIV=8, DEAD_CYCLES=2,
// BLINK_FRAMES=2; cycle c is the clock period following reset edge c-1.
module tb_stopwatch_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_M1, digit_M0, digit_S1, digit_S0;
  logic       start, set_mode, blank_lz;
  logic [1:0] set_sel;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n, digit_err;

  int checks   = 0;
  int failures = 0;
  int cur      = 0;

  stopwatch_display_scan #(
    .REFRESH_DIV (8),
    .DEAD_CYCLES (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digit_M1 (digit_M1),
    .digit_M0 (digit_M0),
    .digit_S1 (digit_S1),
    .digit_S0 (digit_S0),
    .start    (start),
    .set_mode (set_mode),
    .set_sel  (set_sel),
    .blank_lz (blank_lz),
    .an_n     (an_n),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cur, got, exp);
    end
  endtask

  task automatic goto_cycle(input int c);
    while (cur < c) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  task automatic check_slot(input string tag, input logic [3:0] an, input logic [6:0] seg,
                            input logic dp);
    check_eq({tag, "_an"}, 32'(an_n), 32'(an));
    check_eq({tag, "_seg"}, 32'(seg_n), 32'(seg));
    check_eq({tag, "_dp"}, 32'(dp_n), 32'(dp));
  endtask

  initial begin
    reset = 1'b0;
    digit_M1 = 4'd1; digit_M0 = 4'd2; digit_S1 = 4'd3; digit_S0 = 4'd4;
    start = 1'b0; set_mode = 1'b0; set_sel = 2'd0; blank_lz = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    cur = 1;

    check_slot("reset", 4'hF, 7'h7F, 1'b1);
    check_eq("reset_err", 32'(digit_err), 32'd0);

    // Frame 0: first tick in cycle 8, two dark cycles, six lit cycles per slot
    goto_cycle(9);  check_eq("gap9_an", 32'(an_n), 32'hF);
    goto_cycle(10); check_eq("gap10_an", 32'(an_n), 32'hF);
    goto_cycle(11); check_slot("s0_first", 4'b1110, 7'b0011001, 1'b1);
    goto_cycle(16); check_slot("s0_last", 4'b1110, 7'b0011001, 1'b1);
    goto_cycle(17); check_eq("gap17_an", 32'(an_n), 32'hF);
    goto_cycle(20); check_slot("s1_3", 4'b1101, 7'b0110000, 1'b1);
    digit_S0 = 4'd7;
    digit_M1 = 4'd5;
    goto_cycle(28); check_slot("m0_2", 4'b1011, 7'b0100100, 1'b0);
    goto_cycle(36); check_slot("m1_snapped_1", 4'b0111, 7'b1111001, 1'b1);

    // Frame 1: new snapshot picks up S0=7 and M1=5
    goto_cycle(44); check_slot("s0_7", 4'b1110, 7'b1111000, 1'b1);
    digit_S1 = 4'd6;
    goto_cycle(68); check_slot("m1_5", 4'b0111, 7'b0010010, 1'b1);
    goto_cycle(70); check_eq("err_before", 32'(digit_err), 32'd0);

    // Frame 2: illegal S1 snapshotted
    goto_cycle(73); check_eq("err_set", 32'(digit_err), 32'd1);
    digit_S1 = 4'd2;
    goto_cycle(84); check_slot("s1_dash", 4'b1101, 7'b0111111, 1'b1);

    // Frame 3: S1 legal again, error sticky
    goto_cycle(110);
    check_eq("err_sticky", 32'(digit_err), 32'd1);
    digit_M1 = 4'd0;
    blank_lz = 1'b1;
    goto_cycle(116); check_slot("s1_2", 4'b1101, 7'b0100100, 1'b1);

    // Frame 4: leading zero blanked; frame 5: shown once blank_lz drops
    goto_cycle(164); check_eq("lz_blank_an", 32'(an_n), 32'hF);
    goto_cycle(170); blank_lz = 1'b0;
    goto_cycle(196); check_slot("lz_shown", 4'b0111, 7'b1000000, 1'b1);

    // Frames 6..10: M0 blinks in set mode, blink_phase = 1,0,0,1,1
    goto_cycle(197);
    set_mode = 1'b1; set_sel = 2'd2; start = 1'b1;
    goto_cycle(204); check_slot("set_s0_steady", 4'b1110, 7'b1111000, 1'b1);
    goto_cycle(220); check_slot("blink_f6", 4'hF, 7'h7F, 1'b1);
    goto_cycle(252); check_slot("blink_f7", 4'b1011, 7'b0100100, 1'b0);
    goto_cycle(284); check_slot("blink_f8", 4'b1011, 7'b0100100, 1'b0);
    goto_cycle(308); check_slot("set_s1_steady", 4'b1101, 7'b0100100, 1'b1);
    goto_cycle(316); check_slot("blink_f9", 4'hF, 7'h7F, 1'b1);
    goto_cycle(348); check_slot("blink_f10", 4'hF, 7'h7F, 1'b1);

    // Reset during the M1 drive slot of frame 10
    goto_cycle(356);
    check_slot("pre_reset_m1", 4'b0111, 7'b1000000, 1'b1);
    check_eq("pre_reset_err", 32'(digit_err), 32'd1);
    reset = 1'b0;
    goto_cycle(357);
    reset = 1'b1;
    check_slot("mid_reset", 4'hF, 7'h7F, 1'b1);
    check_eq("mid_reset_err", 32'(digit_err), 32'd0);
    goto_cycle(366); check_eq("resume_gap_an", 32'(an_n), 32'hF);
    goto_cycle(367); check_slot("resume_s0", 4'b1110, 7'b1111000, 1'b1);
    check_eq("resume_err", 32'(digit_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
